// File: rtl/bfly_node_arbiter_if.sv
// Handshake bundle for one butterfly switch node:
// per-port input flits, output flits and error pulses.
interface bfly_node_arbiter_if #(
  parameter int RADIX = 4,
  parameter int CHANNEL_WIDTH = 18
);
  logic [RADIX-1:0][CHANNEL_WIDTH-1:0] in_ch;
  logic [RADIX-1:0]                    in_valid;
  logic [RADIX-1:0]                    in_ready;
  logic [RADIX-1:0][CHANNEL_WIDTH-1:0] out_ch;
  logic [RADIX-1:0]                    out_valid;
  logic [RADIX-1:0]                    out_ready;
  logic [RADIX-1:0]                    proto_err;

  modport master (
    output in_ch, in_valid, out_ready,
    input  in_ready, out_ch, out_valid, proto_err
  );

  modport slave (
    input  in_ch, in_valid, out_ready,
    output in_ready, out_ch, out_valid, proto_err
  );
endinterface

// File: rtl/bfly_node_arbiter.sv
// Butterfly switch node: 2-deep input FIFOs, per-output
// round-robin wormhole arbitration with packet lock.
module bfly_node_arbiter #(
  parameter int RADIX = 4,
  parameter int CHANNEL_WIDTH = 18,
  parameter int STAGE = 0
) (
  input logic clk,
  input logic rst,
  bfly_node_arbiter_if.slave bus
);
  localparam int LG = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam int CW = CHANNEL_WIDTH;
  localparam int DLO = LG * STAGE;

  typedef logic [LG-1:0] idx_t;
  typedef enum logic {IDLE, BUSY} st_t;

  logic [CW-1:0] mem [RADIX][2];
  logic [RADIX-1:0] rp;
  logic [RADIX-1:0] wp;
  logic [1:0] cnt [RADIX];
  logic [CW-1:0] front [RADIX];
  logic [RADIX-1:0] nempty;
  logic [RADIX-1:0] rdy;
  logic [RADIX-1:0] push;
  logic [RADIX-1:0] pop;
  logic [RADIX-1:0] orphan;
  logic [RADIX-1:0] owned;

  st_t  st [RADIX];
  idx_t owner [RADIX];
  idx_t rr [RADIX];
  logic [RADIX-1:0] gv;
  idx_t gnt [RADIX];

  logic [RADIX-1:0] ovld;
  logic [RADIX-1:0][CW-1:0] och;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovld;
  assign bus.out_ch    = och;
  assign bus.proto_err = orphan;

  // FIFO status; ready comes from the count register only
  always_comb begin
    for (int i = 0; i < RADIX; i++) begin
      front[i]  = mem[i][rp[i]];
      nempty[i] = cnt[i] != 2'd0;
      rdy[i]    = !rst && (cnt[i] != 2'd2);
      push[i]   = bus.in_valid[i] && rdy[i];
    end
  end

  // Output mux, pops from owners and orphan drops
  always_comb begin
    owned  = '0;
    ovld   = '0;
    och    = '0;
    pop    = '0;
    orphan = '0;
    for (int o = 0; o < RADIX; o++) begin
      if (st[o] == BUSY) owned[owner[o]] = 1'b1;
    end
    for (int o = 0; o < RADIX; o++) begin
      if (st[o] == BUSY && nempty[owner[o]]) begin
        ovld[o] = 1'b1;
        och[o]  = front[owner[o]];
        if (bus.out_ready[o]) pop[owner[o]] = 1'b1;
      end
    end
    for (int i = 0; i < RADIX; i++) begin
      orphan[i] = nempty[i] && !front[i][CW-1] && !owned[i];
      if (orphan[i]) pop[i] = 1'b1;
    end
  end

  // Round-robin pick of a head flit addressed to each output
  always_comb begin
    idx_t c;
    c = '0;
    for (int o = 0; o < RADIX; o++) begin
      gv[o]  = 1'b0;
      gnt[o] = '0;
      for (int k = 1; k <= RADIX; k++) begin
        c = rr[o] + idx_t'(k);
        if (!gv[o] && nempty[c] && front[c][CW-1] &&
            !owned[c] &&
            front[c][DLO +: LG] == idx_t'(o)) begin
          gv[o]  = 1'b1;
          gnt[o] = c;
        end
      end
    end
  end

  // Input FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      for (int i = 0; i < RADIX; i++) begin
        cnt[i]    <= 2'd0;
        mem[i][0] <= '0;
        mem[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < RADIX; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= bus.in_ch[i];
          wp[i] <= ~wp[i];
        end
        if (pop[i]) rp[i] <= ~rp[i];
        cnt[i] <= cnt[i] + {1'b0, push[i]}
                         - {1'b0, pop[i]};
      end
    end
  end

  // Per-output lock FSM: grant on head, release on tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < RADIX; o++) begin
        st[o]    <= IDLE;
        owner[o] <= '0;
        rr[o]    <= idx_t'(RADIX - 1);
      end
    end else begin
      for (int o = 0; o < RADIX; o++) begin
        if (st[o] == IDLE) begin
          if (gv[o]) begin
            st[o]    <= BUSY;
            owner[o] <= gnt[o];
          end
        end else begin
          if (ovld[o] && bus.out_ready[o] &&
              och[o][CW-2]) begin
            st[o] <= IDLE;
            rr[o] <= owner[o];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bfly_node_arbiter.sv
// Directed bench for the butterfly node: routing
// table, contention, wormhole, stall, orphan, reset.
module tb_bfly_node_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bfly_node_arbiter_if #(.RADIX(4), .CHANNEL_WIDTH(18)) bif ();

  bfly_node_arbiter #(
    .RADIX(4),
    .CHANNEL_WIDTH(18),
    .STAGE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    int          port;
    int          cyc;
    logic [17:0] f;
  } ev_t;

  typedef struct {
    int          src;
    logic [15:0] pl;
    int          exp_port;
  } vec_t;

  ev_t lg[$];
  ev_t pq[$];
  logic [17:0] txq [4][$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 4; o++) begin
        if (bif.out_valid[o] && bif.out_ready[o])
          lg.push_back('{port: o, cyc: cyc,
                         f: bif.out_ch[o]});
        if (!bif.out_valid[o])
          chk("och_idle_zero",
              32'(bif.out_ch[o]), 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic collect(input int p);
    pq.delete();
    foreach (lg[k])
      if (lg[k].port == p) pq.push_back(lg[k]);
  endtask

  task automatic drive(input int p);
    int g;
    while (txq[p].size() > 0) begin
      bif.in_ch[p]    = txq[p][0];
      bif.in_valid[p] = 1'b1;
      g = 0;
      @(negedge clk);
      while (!bif.in_ready[p] && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL drv_timeout port %0d got stuck expected ready", p);
        txq[p].delete();
      end else begin
        void'(txq[p].pop_front());
      end
      @(posedge clk);
      #1;
    end
    bif.in_valid[p] = 1'b0;
    bif.in_ch[p]    = '0;
  endtask

  task automatic run_tx();
    fork
      drive(0);
      drive(1);
      drive(2);
      drive(3);
    join
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    lg.delete();
  endtask

  vec_t        vt [6];
  int          exp1 [4];
  int          exp2 [4];
  logic [17:0] wexp [6];
  logic [17:0] bexp [3];
  logic [17:0] f;
  int          c0;

  initial begin
    vt[0] = '{src: 0, pl: 16'h1232, exp_port: 2};
    vt[1] = '{src: 1, pl: 16'hBEEF, exp_port: 3};
    vt[2] = '{src: 2, pl: 16'h0004, exp_port: 0};
    vt[3] = '{src: 3, pl: 16'h7771, exp_port: 1};
    vt[4] = '{src: 0, pl: 16'hFFFC, exp_port: 0};
    vt[5] = '{src: 3, pl: 16'h0003, exp_port: 3};
    exp1 = '{0, 1, 2, 3};
    exp2 = '{2, 3, 0, 1};
    wexp[0] = {2'b10, 16'h0100};
    wexp[1] = {2'b00, 16'h1111};
    wexp[2] = {2'b00, 16'h2222};
    wexp[3] = {2'b01, 16'h3333};
    wexp[4] = {2'b10, 16'h0200};
    wexp[5] = {2'b01, 16'h4444};
    bexp[0] = {2'b10, 16'h0A03};
    bexp[1] = {2'b00, 16'h0B0B};
    bexp[2] = {2'b01, 16'h0C0C};

    rst = 1'b1;
    bif.in_ch     = '0;
    bif.in_valid  = '0;
    bif.out_ready = '1;
    #1;
    chk("rst_in_ready", 32'(bif.in_ready), 32'h0);
    tick(2);
    chk("rst_in_ready_hold", 32'(bif.in_ready), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("in_ready_after_rst", 32'(bif.in_ready), 32'hF);
    chk("out_valid_after_rst", 32'(bif.out_valid), 32'h0);
    chk("proto_err_after_rst", 32'(bif.proto_err), 32'h0);
    chk("out_ch_after_rst", 32'(|bif.out_ch), 32'h0);

    for (int v = 0; v < 6; v++) begin
      lg.delete();
      c0 = cyc;
      f  = {2'b11, vt[v].pl};
      bif.in_valid[vt[v].src] = 1'b1;
      bif.in_ch[vt[v].src]    = f;
      tick(1);
      bif.in_valid[vt[v].src] = 1'b0;
      bif.in_ch[vt[v].src]    = '0;
      tick(4);
      chk($sformatf("vec%0d_count", v), lg.size(), 1);
      if (lg.size() == 1) begin
        chk($sformatf("vec%0d_port", v),
            lg[0].port, vt[v].exp_port);
        chk($sformatf("vec%0d_flit", v), 32'(lg[0].f), 32'(f));
        chk($sformatf("vec%0d_lat", v), lg[0].cyc, c0 + 2);
      end
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      bif.in_valid[i] = 1'b1;
      bif.in_ch[i]    = {2'b11, 8'(i), 8'h01};
    end
    tick(1);
    bif.in_valid = '0;
    bif.in_ch    = '0;
    tick(12);
    collect(1);
    chk("cont1_count", pq.size(), 4);
    for (int k = 0; k < pq.size() && k < 4; k++)
      chk($sformatf("cont1_src%0d", k),
          32'(pq[k].f[15:8]), exp1[k]);
    chk("cont1_other_ports", lg.size(), 4);

    bif.in_valid[1] = 1'b1;
    bif.in_ch[1]    = {2'b11, 8'h01, 8'h01};
    tick(1);
    bif.in_valid = '0;
    bif.in_ch    = '0;
    tick(5);
    lg.delete();
    for (int i = 0; i < 4; i++) begin
      bif.in_valid[i] = 1'b1;
      bif.in_ch[i]    = {2'b11, 8'(i), 8'h01};
    end
    tick(1);
    bif.in_valid = '0;
    bif.in_ch    = '0;
    tick(12);
    collect(1);
    chk("cont2_count", pq.size(), 4);
    for (int k = 0; k < pq.size() && k < 4; k++)
      chk($sformatf("cont2_src%0d", k),
          32'(pq[k].f[15:8]), exp2[k]);

    lg.delete();
    for (int k = 0; k < 4; k++) txq[1].push_back(wexp[k]);
    for (int k = 4; k < 6; k++) txq[2].push_back(wexp[k]);
    run_tx();
    tick(10);
    collect(0);
    chk("worm_count", pq.size(), 6);
    for (int k = 0; k < pq.size() && k < 6; k++)
      chk($sformatf("worm_flit%0d", k),
          32'(pq[k].f), 32'(wexp[k]));
    if (pq.size() == 6) begin
      for (int k = 1; k < 4; k++)
        chk($sformatf("worm_contig%0d", k),
            pq[k].cyc, pq[0].cyc + k);
      chk("worm_in2_after_tail",
          32'(pq[4].cyc > pq[3].cyc), 32'd1);
    end

    lg.delete();
    bif.out_ready[3] = 1'b0;
    bif.in_valid[0]  = 1'b1;
    bif.in_ch[0]     = bexp[0];
    tick(1);
    chk("bp_ready_one", 32'(bif.in_ready[0]), 32'd1);
    bif.in_ch[0] = bexp[1];
    tick(1);
    bif.in_valid[0] = 1'b0;
    bif.in_ch[0]    = '0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp_full%0d", s),
          32'(bif.in_ready[0]), 32'd0);
      chk($sformatf("bp_valid%0d", s),
          32'(bif.out_valid[3]), 32'd1);
      chk($sformatf("bp_stable%0d", s),
          32'(bif.out_ch[3]), 32'(bexp[0]));
      tick(1);
    end
    bif.out_ready[3] = 1'b1;
    txq[0].push_back(bexp[2]);
    run_tx();
    tick(8);
    collect(3);
    chk("bp_count", pq.size(), 3);
    for (int k = 0; k < pq.size() && k < 3; k++)
      chk($sformatf("bp_flit%0d", k),
          32'(pq[k].f), 32'(bexp[k]));

    lg.delete();
    bif.in_valid[3] = 1'b1;
    bif.in_ch[3]    = {2'b00, 16'h5555};
    tick(1);
    bif.in_valid[3] = 1'b0;
    bif.in_ch[3]    = '0;
    chk("orphan_pulse", 32'(bif.proto_err), 32'h8);
    tick(1);
    chk("orphan_clear", 32'(bif.proto_err), 32'h0);
    tick(3);
    chk("orphan_dropped", lg.size(), 0);

    lg.delete();
    bif.in_valid[0] = 1'b1;
    bif.in_ch[0]    = {2'b10, 16'h0002};
    tick(1);
    bif.in_ch[0] = {2'b00, 16'h9999};
    tick(1);
    bif.in_valid[0] = 1'b0;
    bif.in_ch[0]    = '0;
    chk("rstmid_busy", 32'(bif.out_valid[2]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_valid_drop", 32'(bif.out_valid), 32'h0);
    chk("rstmid_ready_drop", 32'(bif.in_ready), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    c0 = cyc;
    bif.in_valid[1] = 1'b1;
    bif.in_ch[1]    = {2'b11, 16'h0AB2};
    tick(1);
    bif.in_valid[1] = 1'b0;
    bif.in_ch[1]    = '0;
    tick(5);
    chk("rstmid_count", lg.size(), 1);
    if (lg.size() == 1) begin
      chk("rstmid_port", lg[0].port, 2);
      chk("rstmid_flit", 32'(lg[0].f),
          32'({2'b11, 16'h0AB2}));
      chk("rstmid_lat", lg[0].cyc, c0 + 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
